fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter IMEM_LATENCY, default 2: fixed cycles from imem_req to imem_rdata valid, legal range 1-4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, power of two, at least IMEM_LATENCY+1.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port redirect_valid, input, 1 bit: a branch, JAL or JALR resolved to a new PC.
REQ-007 SHALL have port redirect_pc, input, 32 bits: redirect target; bits [1:0] ignored, treated as 0.
REQ-008 SHALL have port imem_req, output, 1 bit: read request to instruction memory this cycle.
REQ-009 SHALL have port imem_addr, output, 32 bits: word-aligned byte address of the request.
REQ-010 SHALL have port imem_rdata, input, 32 bits: instruction word, valid exactly IMEM_LATENCY cycles after its request.
REQ-011 SHALL have port out_valid, output, 1 bit: the head instruction is available to the decoder.
REQ-012 SHALL have port out_ready, input, 1 bit: the decoder accepts the head; a pop occurs when out_valid and out_ready are both 1.
REQ-013 SHALL have port out_inst, output, 32 bits: raw instruction word for decode.
REQ-014 SHALL have port out_pc, output, 32 bits: address out_inst was fetched from.

Function
REQ-015 SHALL hold a fetch PC register; each issued request uses imem_addr = PC, then PC <= PC + 4, with 32'hFFFF_FFFC wrapping to 32'h0.
REQ-016 SHALL track in-flight requests in an IMEM_LATENCY-deep valid/PC shift pipeline.
REQ-017 SHALL assert imem_req only when (FIFO occupancy + in-flight count) < FIFO_DEPTH, so returning data never overflows the FIFO; a pop in the same cycle does not raise this credit.
REQ-018 SHALL push {imem_rdata, PC of request} into the FIFO in the cycle the response returns; out_valid rises the following cycle, giving request-to-out_valid latency IMEM_LATENCY+1.
REQ-019 SHALL present the FIFO head on out_inst and out_pc in program order, and SHALL drive both to 0 whenever out_valid is 0.
REQ-020 SHALL sustain one instruction per cycle when out_ready is held at 1.
REQ-021 SHALL hold out_inst and out_pc stable while out_valid=1 and out_ready=0.
REQ-022 On redirect_valid=1 in cycle t, the following SHALL occur:
 - FIFO is flushed.
 - All in-flight responses are discarded on return.
 - PC <= {redirect_pc[31:2], 2'b00}.
 - imem_req is 0 in cycle t.
REQ-023 After a redirect in cycle t, out_valid SHALL be 0 from t+1 until the redirect-target instruction arrives.
REQ-024 After a redirect in cycle t, the first new request SHALL issue in t+1.
REQ-025 A pop coinciding with a redirect SHALL be ignored, because the flush dominates.
REQ-026 A response returning in the redirect cycle SHALL NOT be pushed.
REQ-027 Back-to-back redirects SHALL each take effect; only the last target is fetched.
REQ-028 SHALL perform no decoding or validity check of instruction bits.

Reset
REQ-029 While rst_in=1, the block SHALL hold:
 - PC=RESET_PC.
 - FIFO empty.
 - In-flight pipeline cleared.
 - imem_req=0, imem_addr=0.
 - out_valid=0, out_inst=0, out_pc=0.
REQ-030 The first request SHALL issue in the first clock edge cycle after rst_in falls, at RESET_PC.
REQ-031 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions immediately, without waiting for a clock edge.

Verification
REQ-032 Scenario: reset release, out_ready=1, imem returns word = addr ^ 32'hA5A5_0000 -> requests at 0,4,8,...; first out_valid 3 cycles after first request with out_pc=0; then one instruction per cycle in order.
REQ-033 Scenario: out_ready=0 for 10 cycles -> exactly 4 requests issued, then imem_req=0; FIFO holds pcs 0,4,8,12; out_inst stable; on out_ready=1, drain in order with no loss or duplication.
REQ-034 Scenario: redirect_valid=1 with redirect_pc=32'h0000_0103 while 2 requests are in flight -> next imem_addr=32'h100; stale responses never appear on out_pc; first output has out_pc=32'h100.
REQ-035 Scenario: redirect and pop in the same cycle, then redirect on 2 consecutive cycles (0x200, then 0x300) -> only 0x300 stream appears; no 0x200 instruction is ever output.
REQ-036 Scenario: redirect_pc=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 Scenario: rst_in pulsed asynchronously mid-stream with FIFO at 3 entries -> out_valid drops immediately; after release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues word-aligned reads to a fixed-latency instruction memory, tracks
// in-flight requests, buffers returned words in a small FIFO and presents
// them in program order to the decoder with a valid/ready handshake.
// A redirect flushes the buffer, discards in-flight responses and restarts
// fetch at the new target.
//
// Ports:
//   clk_in          single clock, rising edge
//   rst_in          asynchronous active-high reset
//   redirect_valid  resolved branch/JAL/JALR, redirect_pc is the new PC
//   redirect_pc     redirect target, bits [1:0] ignored
//   imem_req        memory read request this cycle
//   imem_addr       word-aligned request address (0 when not requesting)
//   imem_rdata      instruction word, valid IMEM_LATENCY cycles after request
//   out_valid       FIFO head available to decode
//   out_ready       decoder accepts the head
//   out_inst        head instruction word (0 when out_valid is 0)
//   out_pc          head fetch address (0 when out_valid is 0)
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 2;
  localparam int unsigned PW = IMEM_LATENCY * 32;

  logic [31:0]             pc_q;
  logic [IMEM_LATENCY-1:0] pipe_vld_q;
  logic [PW-1:0]           pipe_pc_q;
  logic [31:0]             fifo_inst [FIFO_DEPTH];
  logic [31:0]             fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0]           rd_ptr_q;
  logic [AW-1:0]           wr_ptr_q;
  logic [AW:0]             count_q;
  logic [CW-1:0]           inflight;
  logic                    credit_ok;
  logic                    resp_valid;
  logic [31:0]             resp_pc;
  logic                    push;
  logic                    pop;
  logic                    unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Credit: every issued request owns a FIFO slot until it is popped, so
  // occupancy plus in-flight never exceeds the depth. Same-cycle pops are
  // deliberately not credited.
  assign inflight  = CW'($countones(pipe_vld_q));
  assign credit_ok = (CW'(count_q) + inflight) < CW'(FIFO_DEPTH);

  // Request is suppressed combinationally in reset and in the redirect cycle.
  assign imem_req  = !rst_in && !redirect_valid && credit_ok;
  assign imem_addr = imem_req ? pc_q : 32'h0;

  // Oldest pipeline stage is the response returning this cycle.
  assign resp_valid = pipe_vld_q[IMEM_LATENCY-1];
  assign resp_pc    = pipe_pc_q[PW-1 -: 32];
  assign push       = resp_valid && !redirect_valid;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_inst  = out_valid ? fifo_inst[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr_q]   : 32'h0;

  // Fetch PC: advances per issued request, 32-bit add wraps FFFF_FFFC to 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (imem_req) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // In-flight tracking; a redirect kills every outstanding response.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_vld_q <= '0;
      pipe_pc_q  <= '0;
    end else if (redirect_valid) begin
      pipe_vld_q <= '0;
      pipe_pc_q  <= '0;
    end else begin
      pipe_vld_q <= (pipe_vld_q << 1) | IMEM_LATENCY'(imem_req);
      pipe_pc_q  <= (pipe_pc_q << 32) | PW'(pc_q);
    end
  end

  // FIFO storage; contents are only visible through out_valid gating.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]   <= resp_pc;
    end
  end

  // FIFO pointers and occupancy; flush dominates any push or pop.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: fixed-latency memory model, directed scenarios
// followed by randomized redirects/backpressure, scoreboard checked by a
// negedge monitor against a program-order stream model.
module tb_fetch_unit;

  localparam int          L        = 2;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk_in;
  logic        rst_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  fetch_unit #(
    .RESET_PC    (RST_PC),
    .IMEM_LATENCY(L),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  // Reference model: expected fetch address stream, expected output stream,
  // and the number of requests owned by the front end (issued, not popped).
  exp_t        exp_q[$];
  logic [31:0] tail_pc;
  logic [31:0] exp_fetch;
  int          outstanding;
  bit          awaiting;
  bit          seen_first;
  int          first_req_cyc;
  bit          saw_200;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back({tail_pc, tail_pc ^ KEY});
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  task automatic flush_model(input logic [31:0] target);
    exp_fetch   = target;
    outstanding = 0;
    exp_q.delete();
    tail_pc     = target;
    refill();
    awaiting    = 1'b1;
    seen_first  = 1'b0;
  endtask

  // Instruction memory: answers each request exactly L cycles later.
  int          due_q[$];
  logic [31:0] addr_q[$];
  int          due_tmp;
  logic [31:0] addr_tmp;
  initial imem_rdata = 32'h0;
  always begin
    @(negedge clk_in);
    if (imem_req) begin
      due_q.push_back(cyc + L);
      addr_q.push_back(imem_addr);
    end
    @(posedge clk_in);
    cyc++;
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      due_tmp    = due_q.pop_front();
      addr_tmp   = addr_q.pop_front();
      imem_rdata = addr_tmp ^ KEY;
    end else begin
      imem_rdata = $urandom();
    end
  end

  // Monitor / scoreboard.
  bit          prev_ok = 1'b0;
  bit          prev_valid, prev_ready, prev_redir;
  logic [31:0] prev_inst, prev_pc;
  bit          exp_req;
  exp_t        e;
  always @(negedge clk_in) begin
    if (rst_in) begin
      check(!imem_req && imem_addr == 32'h0 && !out_valid && out_inst == 32'h0 && out_pc == 32'h0,
            "reset_outputs", out_inst | out_pc | imem_addr | 32'({imem_req, out_valid}), 32'h0);
      prev_ok = 1'b0;
    end else begin
      exp_req = !redirect_valid && (outstanding < DEPTH);
      check(imem_req == exp_req, "imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) begin
        check(imem_addr == exp_fetch, "imem_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        outstanding++;
        if (!seen_first) begin
          seen_first    = 1'b1;
          first_req_cyc = cyc;
        end
      end
      if (!out_valid)
        check(out_inst == 32'h0 && out_pc == 32'h0, "idle_zero", out_inst | out_pc, 32'h0);
      if (prev_ok && prev_valid && !prev_ready && !prev_redir)
        check(out_valid && out_inst == prev_inst && out_pc == prev_pc, "stall_hold", out_pc, prev_pc);
      if (!redirect_valid && awaiting && out_valid) begin
        check(seen_first && (cyc - first_req_cyc == L + 1), "first_latency",
              32'(cyc - first_req_cyc), 32'(L + 1));
        awaiting = 1'b0;
      end
      if (out_valid && out_pc >= 32'h200 && out_pc < 32'h300)
        saw_200 = 1'b1;
      if (out_valid && out_ready && !redirect_valid) begin
        e = exp_q.pop_front();
        check(out_pc == e.pc && out_inst == e.inst, "out_data", out_pc, e.pc);
        outstanding--;
        refill();
      end
      prev_ok = 1'b1;
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_redir = redirect_valid;
    prev_inst  = out_inst;
    prev_pc    = out_pc;
  end

  // Drive one cycle of inputs just after the edge, return at the negedge.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    @(posedge clk_in);
    #1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (rv) flush_model({rpc[31:2], 2'b00});
    @(negedge clk_in);
  endtask

  task automatic reset_pulse(input bit rdy);
    @(posedge clk_in);
    #1;
    rst_in         = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = rdy;
    flush_model(RST_PC);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  int          nreq;
  logic [31:0] held;
  logic [31:0] wrap_addr [4];

  initial begin
    rst_in         = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    saw_200        = 1'b0;
    flush_model(RST_PC);
    repeat (3) @(negedge clk_in);

    // Reset release, streaming with ready held high.
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check(imem_req && imem_addr == RST_PC, "first_req", imem_addr, RST_PC);
    step(0, 0, 1);
    step(0, 0, 1);
    check(!out_valid, "no_early_valid", 32'(out_valid), 32'h0);
    step(0, 0, 1);
    check(out_valid && out_pc == RST_PC, "first_out_pc", out_pc, RST_PC);
    repeat (20) step(0, 0, 1);

    // Backpressure: credit limits requests to the FIFO depth.
    reset_pulse(0);
    nreq = imem_req ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0);
      if (imem_req) nreq++;
      if (i == 4) held = out_inst;
    end
    check(nreq == DEPTH, "stall_req_count", 32'(nreq), 32'(DEPTH));
    check(!imem_req, "stall_req_off", 32'(imem_req), 32'h0);
    check(out_valid && out_inst == held && out_pc == RST_PC, "stall_head", out_inst, held);
    repeat (12) step(0, 0, 1);

    // Redirect with requests in flight; low target bits ignored.
    step(1, 32'h0000_0103, 1);
    check(!imem_req, "redir_no_req", 32'(imem_req), 32'h0);
    step(0, 0, 1);
    check(imem_req && imem_addr == 32'h100, "redir_first_req", imem_addr, 32'h100);
    check(!out_valid, "redir_flush_t1", 32'(out_valid), 32'h0);
    step(0, 0, 1);
    check(!out_valid, "redir_flush_t2", 32'(out_valid), 32'h0);
    step(0, 0, 1);
    check(!out_valid, "redir_flush_t3", 32'(out_valid), 32'h0);
    step(0, 0, 1);
    check(out_valid && out_pc == 32'h100, "redir_first_out", out_pc, 32'h100);
    repeat (10) step(0, 0, 1);

    // Redirect coinciding with a pop, then back-to-back redirects.
    check(out_valid, "pop_redir_setup", 32'(out_valid), 32'h1);
    step(1, 32'h80, 1);
    repeat (6) step(0, 0, 1);
    saw_200 = 1'b0;
    step(1, 32'h200, 1);
    step(1, 32'h300, 1);
    check(imem_req == 1'b0, "b2b_no_req", 32'(imem_req), 32'h0);
    repeat (12) step(0, 0, 1);
    check(!saw_200, "no_200_output", 32'(saw_200), 32'h0);

    // Address wrap at the top of the address space.
    step(1, 32'hFFFF_FFF8, 1);
    wrap_addr[0] = 32'hFFFF_FFF8;
    wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000;
    wrap_addr[3] = 32'h0000_0004;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      check(imem_req && imem_addr == wrap_addr[i], "wrap_addr", imem_addr, wrap_addr[i]);
    end
    repeat (8) step(0, 0, 1);

    // Asynchronous reset mid-stream with three buffered entries.
    reset_pulse(0);
    repeat (5) step(0, 0, 0);
    #2;
    check(out_valid, "pre_async_valid", 32'(out_valid), 32'h1);
    rst_in = 1'b1;
    flush_model(RST_PC);
    #1;
    check(!out_valid && out_inst == 32'h0 && out_pc == 32'h0, "async_reset_drop",
          32'(out_valid), 32'h0);
    repeat (2) @(negedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk_in);
    check(imem_req && imem_addr == RST_PC, "restart_req", imem_addr, RST_PC);
    repeat (10) step(0, 0, 1);

    // Randomized redirects and backpressure.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom(), ($urandom_range(0, 3) != 0));
    end
    repeat (12) step(0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
